// File: rtl/led_pwm_scheduler.sv
// Two-requester round-robin duty writer feeding a double-buffered PWM LED bank.
// Define LED_PWM_SCHEDULER_FADE_EN to make shadow duties auto-fade once per frame.
module led_pwm_scheduler #(
    parameter int PRESCALE = 255,
    parameter int NUM_LEDS = 11
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [3:0]          a_idx,
    input  logic [7:0]          a_duty,
    input  logic                b_valid,
    output logic                b_ready,
    input  logic [3:0]          b_idx,
    input  logic [7:0]          b_duty,
    output logic [NUM_LEDS-1:0] ledc,
    output logic                frame,
    output logic [7:0]          drop_cnt
);

    localparam int PW = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE);
    localparam logic [4:0] NL = 5'(NUM_LEDS);

    logic [PW-1:0] presc;
    logic [PW-1:0] presc_nxt;
    logic [7:0]    pwm_cnt;
    logic [7:0]    pwm_nxt;
    logic          tick;
    logic          wrap;
    logic          last_b;
    logic          xfer;
    logic          w_ok;
    logic [3:0]    w_idx;
    logic [7:0]    w_duty;
    logic [7:0]    shadow [NUM_LEDS];
    logic [7:0]    active [NUM_LEDS];

    assign tick      = (presc == PMAX);
    assign wrap      = tick && (pwm_cnt == 8'hFF);
    assign presc_nxt = tick ? '0 : presc + PW'(1);
    assign pwm_nxt   = tick ? pwm_cnt + 8'd1 : pwm_cnt;

    // Requester not granted last wins a tie; last_b resets to B so A goes first.
    assign a_ready = !rst && a_valid && (!b_valid || last_b);
    assign b_ready = !rst && b_valid && (!a_valid || !last_b);

    assign xfer   = a_ready || b_ready;
    assign w_idx  = a_ready ? a_idx : b_idx;
    assign w_duty = a_ready ? a_duty : b_duty;
    assign w_ok   = ({1'b0, w_idx} < NL);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc    <= '0;
            pwm_cnt  <= '0;
            frame    <= 1'b0;
            last_b   <= 1'b1;
            drop_cnt <= '0;
        end else begin
            presc   <= presc_nxt;
            pwm_cnt <= pwm_nxt;
            // Registered look-ahead: high during the cycle whose end wraps pwm_cnt.
            frame   <= (presc_nxt == PMAX) && (pwm_nxt == 8'hFF);
            if (a_ready) begin
                last_b <= 1'b0;
            end else if (b_ready) begin
                last_b <= 1'b1;
            end
            if (xfer && !w_ok && (drop_cnt != 8'hFF)) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LEDS; i++) begin
            if (rst) begin
                shadow[i] <= '0;
                active[i] <= '0;
                ledc[i]   <= 1'b0;
            end else begin
                ledc[i] <= (pwm_cnt < active[i]);
                if (wrap) begin
                    active[i] <= shadow[i];
                end
                if (xfer && w_ok && (w_idx == 4'(i))) begin
                    shadow[i] <= w_duty;
                end
`ifdef LED_PWM_SCHEDULER_FADE_EN
                else if (wrap && (shadow[i] != 8'd0)) begin
                    shadow[i] <= shadow[i] - 8'd1;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_led_pwm_scheduler.sv
// Self-checking bench for led_pwm_scheduler: vector table, directed
// frame/contention/drop sequences, and a randomized run against a frame model.
`timescale 1ns/1ps
module tb_led_pwm_scheduler;

    localparam int PRESCALE = 0;
    localparam int NUM_LEDS = 11;
    localparam int P1       = PRESCALE + 1;
    localparam int FRAME    = 256 * P1;

    logic                clk = 1'b0;
    logic                rst;
    logic                a_valid;
    logic                a_ready;
    logic [3:0]          a_idx;
    logic [7:0]          a_duty;
    logic                b_valid;
    logic                b_ready;
    logic [3:0]          b_idx;
    logic [7:0]          b_duty;
    logic [NUM_LEDS-1:0] ledc;
    logic                frame;
    logic [7:0]          drop_cnt;

    led_pwm_scheduler #(.PRESCALE(PRESCALE), .NUM_LEDS(NUM_LEDS)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_idx(a_idx), .a_duty(a_duty),
        .b_valid(b_valid), .b_ready(b_ready), .b_idx(b_idx), .b_duty(b_duty),
        .ledc(ledc), .frame(frame), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    // Reference model: k = clock edges since reset released.
    int                  m_k;
    int                  m_sh [NUM_LEDS];
    int                  m_act [NUM_LEDS];
    bit                  m_last_b;
    int                  m_drop;
    logic [NUM_LEDS-1:0] m_ledc;
    bit                  m_frame;

    typedef struct {
        bit         av;
        bit         bv;
        logic [3:0] ai;
        logic [3:0] bi;
        logic [7:0] ad;
        logic [7:0] bd;
        bit         ea;
        bit         eb;
    } vec_t;
    vec_t tbl [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic m_write(input logic [3:0] idx, input logic [7:0] d);
        if (int'(idx) < NUM_LEDS) m_sh[idx] = int'(d);
        else if (m_drop < 255) m_drop++;
    endtask

    task automatic step();
        bit ra;
        bit rb;
        int pre_pwm;
        bit pre_tick;
        logic [3:0] ai, bi;
        logic [7:0] ad, bd;
        #1;
        ra = !rst && a_valid && (!b_valid || m_last_b);
        rb = !rst && b_valid && (!a_valid || !m_last_b);
        ai = a_idx; ad = a_duty; bi = b_idx; bd = b_duty;
        chk("a_ready", 32'(a_ready), 32'(ra));
        chk("b_ready", 32'(b_ready), 32'(rb));
        @(posedge clk);
        if (rst) begin
            m_k = 0;
            m_last_b = 1'b1;
            m_drop = 0;
            m_ledc = '0;
            m_frame = 1'b0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                m_sh[i] = 0;
                m_act[i] = 0;
            end
        end else begin
            pre_pwm  = (m_k / P1) % 256;
            pre_tick = (m_k % P1) == P1 - 1;
            for (int i = 0; i < NUM_LEDS; i++) m_ledc[i] = pre_pwm < m_act[i];
            if (pre_tick && pre_pwm == 255) begin
                for (int i = 0; i < NUM_LEDS; i++) m_act[i] = m_sh[i];
`ifdef LED_PWM_SCHEDULER_FADE_EN
                for (int i = 0; i < NUM_LEDS; i++) if (m_sh[i] > 0) m_sh[i]--;
`endif
            end
            if (ra) begin
                m_write(ai, ad);
                m_last_b = 1'b0;
            end else if (rb) begin
                m_write(bi, bd);
                m_last_b = 1'b1;
            end
            m_k++;
            m_frame = (m_k % FRAME) == FRAME - 1;
        end
        #1;
        chk("ledc", 32'(ledc), 32'(m_ledc));
        chk("frame", 32'(frame), 32'(m_frame));
        chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
    endtask

    task automatic write(input bit use_b, input logic [3:0] idx, input logic [7:0] d);
        int n = 0;
        if (use_b) begin b_valid = 1'b1; b_idx = idx; b_duty = d; end
        else begin a_valid = 1'b1; a_idx = idx; a_duty = d; end
        #1;
        while ((use_b ? b_ready : a_ready) !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        chk(use_b ? "b_grant" : "a_grant", 32'(use_b ? b_ready : a_ready), 32'd1);
        step();
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic wait_frame();
        int n = 0;
        do begin
            step();
            n++;
        end while (frame !== 1'b1 && n < FRAME + 8);
        chk("frame_seen", 32'(frame), 32'd1);
    endtask

    task automatic frame_count(input int b, output int n);
        n = 0;
        repeat (FRAME) begin
            step();
            n += int'(ledc[b]);
        end
    endtask

    initial begin
        int n;
        int ga;
        int gb;
        logic [NUM_LEDS-1:0] orv;
        bit acc_a;
        bit acc_b;

        rst = 1'b1;
        a_valid = 1'b0; a_idx = '0; a_duty = '0;
        b_valid = 1'b0; b_idx = '0; b_duty = '0;

        tbl[0]  = '{1, 1, 4'd0, 4'd1, 8'd11, 8'd21, 1, 0};
        tbl[1]  = '{1, 1, 4'd0, 4'd1, 8'd12, 8'd22, 0, 1};
        tbl[2]  = '{1, 1, 4'd0, 4'd1, 8'd13, 8'd23, 1, 0};
        tbl[3]  = '{1, 1, 4'd0, 4'd1, 8'd14, 8'd24, 0, 1};
        tbl[4]  = '{1, 1, 4'd0, 4'd1, 8'd15, 8'd25, 1, 0};
        tbl[5]  = '{1, 1, 4'd0, 4'd1, 8'd16, 8'd26, 0, 1};
        tbl[6]  = '{1, 0, 4'd2, 4'd3, 8'd30, 8'd40, 1, 0};
        tbl[7]  = '{1, 1, 4'd2, 4'd3, 8'd31, 8'd41, 0, 1};
        tbl[8]  = '{0, 1, 4'd2, 4'd3, 8'd32, 8'd42, 0, 1};
        tbl[9]  = '{1, 1, 4'd4, 4'd5, 8'd50, 8'd60, 1, 0};
        tbl[10] = '{0, 0, 4'd4, 4'd5, 8'd51, 8'd61, 0, 0};

        // Reset state; ready must stay low under reset even with valid high.
        a_valid = 1'b1; b_valid = 1'b1;
        repeat (3) step();
        #1;
        chk("rst_a_ready", 32'(a_ready), 32'd0);
        chk("rst_b_ready", 32'(b_ready), 32'd0);
        chk("rst_ledc", 32'(ledc), 32'd0);
        chk("rst_frame", 32'(frame), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        a_valid = 1'b0; b_valid = 1'b0;
        rst = 1'b0;

        // Idle: three frames dark, frame pulse period.
        orv = '0;
        wait_frame();
        repeat (2) begin
            n = 0;
            do begin
                step();
                orv |= ledc;
                n++;
            end while (frame !== 1'b1 && n < FRAME + 8);
            chk("frame_period", 32'(n), 32'(FRAME));
        end
        chk("idle_ledc", 32'(orv), 32'd0);

        // Basic PWM on LED 3.
        do_reset();
        write(1'b0, 4'd3, 8'd64);
        wait_frame();
        step();
        orv = '0;
        n = 0;
        repeat (FRAME) begin
            step();
            n += int'(ledc[3]);
            orv |= ledc & ~(NUM_LEDS'(1) << 3);
        end
        chk("pwm64_on", 32'(n), 32'd64);
        chk("pwm64_others", 32'(orv), 32'd0);

        // Arbitration vector table.
        do_reset();
        ga = 0;
        gb = 0;
        for (int r = 0; r < 11; r++) begin
            a_valid = tbl[r].av; a_idx = tbl[r].ai; a_duty = tbl[r].ad;
            b_valid = tbl[r].bv; b_idx = tbl[r].bi; b_duty = tbl[r].bd;
            #1;
            chk($sformatf("vec%0d_a_ready", r), 32'(a_ready), 32'(tbl[r].ea));
            chk($sformatf("vec%0d_b_ready", r), 32'(b_ready), 32'(tbl[r].eb));
            if (r < 6) begin
                ga += int'(a_ready);
                gb += int'(b_ready);
            end
            step();
        end
        a_valid = 1'b0; b_valid = 1'b0;
        chk("contend_a_writes", 32'(ga), 32'd3);
        chk("contend_b_writes", 32'(gb), 32'd3);

        // Out-of-range writes and drop saturation.
        do_reset();
        write(1'b1, 4'd12, 8'd99);
        write(1'b1, 4'd15, 8'd77);
        chk("drop_two", 32'(drop_cnt), 32'd2);
        chk("drop_ledc", 32'(ledc), 32'd0);
        b_valid = 1'b1; b_idx = 4'd13; b_duty = 8'd5;
        repeat (300) step();
        b_valid = 1'b0;
        step();
        chk("drop_sat", 32'(drop_cnt), 32'd255);

        // Write landing in the frame-pulse cycle.
        do_reset();
        wait_frame();
        step();
        write(1'b0, 4'd0, 8'd10);
        wait_frame();
        a_valid = 1'b1; a_idx = 4'd0; a_duty = 8'd200;
        #1;
        chk("edge_a_ready", 32'(a_ready), 32'd1);
        step();
        a_valid = 1'b0;
        frame_count(0, n);
        chk("edge_frame1", 32'(n), 32'd10);
        frame_count(0, n);
        chk("edge_frame2", 32'(n), 32'd200);

        // Reset mid-frame with a write in flight.
        repeat (50) step();
        rst = 1'b1;
        a_valid = 1'b1; a_idx = 4'd2; a_duty = 8'd99;
        step();
        chk("midrst_ledc", 32'(ledc), 32'd0);
        rst = 1'b0;
        a_valid = 1'b0;
        wait_frame();
        step();
        frame_count(2, n);
        chk("midrst_discard", 32'(n), 32'd0);

`ifdef LED_PWM_SCHEDULER_FADE_EN
        do_reset();
        write(1'b0, 4'd5, 8'd3);
        wait_frame();
        step();
        for (int f = 0; f < 5; f++) begin
            frame_count(5, n);
            chk($sformatf("fade_f%0d", f), 32'(n), 32'(f < 3 ? 3 - f : 0));
        end
`endif

        // Randomized traffic with occasional resets, checked by the model.
        do_reset();
        acc_a = 1'b1;
        acc_b = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (!a_valid || acc_a) begin
                a_valid = 1'($urandom_range(0, 1));
                a_idx = 4'($urandom_range(0, 15));
                a_duty = 8'($urandom_range(0, 255));
            end
            if (!b_valid || acc_b) begin
                b_valid = 1'($urandom_range(0, 2) == 0);
                b_idx = 4'($urandom_range(0, 15));
                b_duty = 8'($urandom_range(0, 255));
            end
            rst = ($urandom_range(0, 399) == 0);
            #1;
            acc_a = a_ready;
            acc_b = b_ready;
            step();
        end
        rst = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
